// File: rtl/piso_serializer_if.sv
// Handshake and serial-line bundle for the parallel-in serial-out transmitter.
// master = upstream word source / link observer, slave = serializer.
interface piso_serializer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] din;
  logic             load_valid;
  logic             load_ready;
  logic             bit_en;
  logic             sout;
  logic             sout_valid;
  logic             frame_start;
  logic             word_done;

  modport master (
    output din, load_valid, bit_en,
    input  load_ready, sout, sout_valid, frame_start, word_done
  );

  modport slave (
    input  din, load_valid, bit_en,
    output load_ready, sout, sout_valid, frame_start, word_done
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: valid/ready word load, bit_en-paced shift-out,
// with a first-bit marker and a one-cycle completion pulse per word.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  piso_serializer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_count;
  logic             r_sout;
  logic             r_sout_valid;
  logic             r_frame_start;
  logic             r_word_done;

  logic             w_last;
  logic             w_load_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_shifted;

  // Bit that sits at the output end of a word for the configured shift order.
  function automatic logic head_bit(input logic [WIDTH-1:0] word);
    return MSB_FIRST ? word[WIDTH-1] : word[0];
  endfunction

  assign w_last       = (r_state == SHIFT) && (r_count == '0) && bus.bit_en;
  assign w_load_ready = !reset && ((r_state == IDLE) || w_last);
  assign w_accept     = bus.load_valid && w_load_ready;
  assign w_shifted    = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0}
                                  : {1'b0, r_shift[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_shift       <= '0;
      r_count       <= '0;
      r_sout        <= 1'b0;
      r_sout_valid  <= 1'b0;
      r_frame_start <= 1'b0;
      r_word_done   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values;
      // the default below makes word_done a pulse without a separate clear path.
      r_word_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state       <= SHIFT;
            r_shift       <= bus.din;
            r_count       <= CW'(WIDTH - 1);
            r_sout        <= head_bit(bus.din);
            r_sout_valid  <= 1'b1;
            r_frame_start <= 1'b1;
          end
        end
        SHIFT: begin
          if (bus.bit_en) begin
            if (r_count != '0) begin
              r_shift       <= w_shifted;
              r_count       <= r_count - 1'b1;
              r_sout        <= head_bit(w_shifted);
              r_frame_start <= 1'b0;
            end else begin
              r_word_done <= 1'b1;
              if (w_accept) begin
                // Back-to-back reload keeps the line busy with no idle gap.
                r_shift       <= bus.din;
                r_count       <= CW'(WIDTH - 1);
                r_sout        <= head_bit(bus.din);
                r_frame_start <= 1'b1;
              end else begin
                r_state       <= IDLE;
                r_shift       <= '0;
                r_sout        <= 1'b0;
                r_sout_valid  <= 1'b0;
                r_frame_start <= 1'b0;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.load_ready  = w_load_ready;
  assign bus.sout        = r_sout;
  assign bus.sout_valid  = r_sout_valid;
  assign bus.frame_start = r_frame_start;
  assign bus.word_done   = r_word_done;
endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: one MSB-first and one LSB-first instance,
// inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_piso_serializer;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  piso_serializer_if #(.WIDTH(4)) if_m ();
  piso_serializer_if #(.WIDTH(4)) if_l ();

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk   (clk),
    .reset (reset),
    .bus   (if_m)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk   (clk),
    .reset (reset),
    .bus   (if_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    logic [4:0] got;
    reset = 1'b1;
    if_m.din = '0; if_m.load_valid = 1'b0; if_m.bit_en = 1'b0;
    if_l.din = '0; if_l.load_valid = 1'b0; if_l.bit_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      got = {if_m.sout, if_m.sout_valid, if_m.frame_start, if_m.word_done, if_m.load_ready};
      n_checks++;
      if (got !== 5'b00000) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got %b expected 00000", i, got);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    got = {if_m.sout, if_m.sout_valid, if_m.frame_start, if_m.word_done, if_m.load_ready};
    n_checks++;
    if (got !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_release_msb: got %b expected 00001", got);
    end
    got = {if_l.sout, if_l.sout_valid, if_l.frame_start, if_l.word_done, if_l.load_ready};
    n_checks++;
    if (got !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_release_lsb: got %b expected 00001", got);
    end
  endtask

  // Word 4'b1110 MSB-first: expected line sequence 1,1,1,0.
  task automatic test_msb_single();
    logic [3:0] seq;
    logic [3:0] got;
    seq = 4'b1110;
    @(negedge clk);
    if_m.din = 4'b1110; if_m.load_valid = 1'b1; if_m.bit_en = 1'b1;
    #1;
    n_checks++;
    if (if_m.load_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL msb_ready_idle: got %b expected 1", if_m.load_ready);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) if_m.load_valid = 1'b0;
      got = {if_m.sout, if_m.sout_valid, if_m.frame_start, if_m.word_done};
      n_checks++;
      if (got !== {seq[3-k], 1'b1, (k == 0), 1'b0}) begin
        n_fail++;
        $display("FAIL msb_bit[%0d]: got %b expected %b", k, got, {seq[3-k], 1'b1, (k == 0), 1'b0});
      end
    end
    @(negedge clk);
    got = {if_m.sout, if_m.sout_valid, if_m.frame_start, if_m.word_done};
    n_checks++;
    if (got !== 4'b0001 || if_m.load_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL msb_done: got %b ready %b expected 0001 ready 1", got, if_m.load_ready);
    end
    @(negedge clk);
    got = {if_m.sout, if_m.sout_valid, if_m.frame_start, if_m.word_done};
    n_checks++;
    if (got !== 4'b0000) begin
      n_fail++;
      $display("FAIL msb_idle_after: got %b expected 0000", got);
    end
  endtask

  // Word 4'b1100 LSB-first: expected line sequence 0,0,1,1.
  task automatic test_lsb_first();
    logic [3:0] seq;
    logic [3:0] got;
    seq = 4'b0011;
    @(negedge clk);
    if_l.din = 4'b1100; if_l.load_valid = 1'b1; if_l.bit_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) if_l.load_valid = 1'b0;
      got = {if_l.sout, if_l.sout_valid, if_l.frame_start, if_l.word_done};
      n_checks++;
      if (got !== {seq[3-k], 1'b1, (k == 0), 1'b0}) begin
        n_fail++;
        $display("FAIL lsb_bit[%0d]: got %b expected %b", k, got, {seq[3-k], 1'b1, (k == 0), 1'b0});
      end
    end
    @(negedge clk);
    got = {if_l.sout, if_l.sout_valid, if_l.frame_start, if_l.word_done};
    n_checks++;
    if (got !== 4'b0001) begin
      n_fail++;
      $display("FAIL lsb_done: got %b expected 0001", got);
    end
    if_l.bit_en = 1'b0;
  endtask

  // 4'b1100 then 4'b1001: eight contiguous bits 1,1,0,0,1,0,0,1.
  task automatic test_back_to_back();
    logic [7:0] seq;
    logic [3:0] got;
    logic [3:0] exp;
    seq = 8'b11001001;
    @(negedge clk);
    if_m.din = 4'b1100; if_m.load_valid = 1'b1; if_m.bit_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) if_m.din = 4'b1001;
      if (k == 4) if_m.load_valid = 1'b0;
      #1;
      got = {if_m.sout, if_m.sout_valid, if_m.frame_start, if_m.word_done};
      exp = {seq[7-k], 1'b1, (k == 0 || k == 4), (k == 4)};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL b2b_bit[%0d]: got %b expected %b", k, got, exp);
      end
      n_checks++;
      if (if_m.load_ready !== (k == 3 || k == 7)) begin
        n_fail++;
        $display("FAIL b2b_ready[%0d]: got %b expected %b", k, if_m.load_ready, (k == 3 || k == 7));
      end
    end
    @(negedge clk);
    got = {if_m.sout, if_m.sout_valid, if_m.frame_start, if_m.word_done};
    n_checks++;
    if (got !== 4'b0001) begin
      n_fail++;
      $display("FAIL b2b_done: got %b expected 0001", got);
    end
  endtask

  // Word 4'b0011, bit_en every third cycle: each bit held three cycles,
  // mid-frame load_valid pulses carrying 4'b1111 must be ignored.
  task automatic test_gated_rate();
    logic [3:0] seq;
    logic [3:0] got;
    logic [3:0] exp;
    seq = 4'b0011;
    @(negedge clk);
    if_m.din = 4'b0011; if_m.load_valid = 1'b1; if_m.bit_en = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      got = {if_m.sout, if_m.sout_valid, if_m.frame_start, if_m.word_done};
      exp = {seq[3-(c/3)], 1'b1, (c < 3), 1'b0};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL gated_cycle[%0d]: got %b expected %b", c, got, exp);
      end
      if_m.load_valid = (c == 4 || c == 5);
      if_m.din        = if_m.load_valid ? 4'b1111 : 4'b0011;
      if_m.bit_en     = (c % 3 == 2);
      #1;
      n_checks++;
      if (if_m.load_ready !== (c == 11)) begin
        n_fail++;
        $display("FAIL gated_ready[%0d]: got %b expected %b", c, if_m.load_ready, (c == 11));
      end
    end
    @(negedge clk);
    if_m.bit_en = 1'b0;
    got = {if_m.sout, if_m.sout_valid, if_m.frame_start, if_m.word_done};
    n_checks++;
    if (got !== 4'b0001) begin
      n_fail++;
      $display("FAIL gated_done: got %b expected 0001", got);
    end
    @(negedge clk);
    got = {if_m.sout, if_m.sout_valid, if_m.frame_start, if_m.word_done};
    n_checks++;
    if (got !== 4'b0000) begin
      n_fail++;
      $display("FAIL gated_pulse_width: got %b expected 0000", got);
    end
  endtask

  // 4'b1001 aborted after two bits, then 4'b0110 sends 0,1,1,0.
  task automatic test_reset_mid_frame();
    logic [3:0] seq;
    logic [3:0] got;
    @(negedge clk);
    if_m.din = 4'b1001; if_m.load_valid = 1'b1; if_m.bit_en = 1'b1;
    @(negedge clk);
    if_m.load_valid = 1'b0;
    got = {if_m.sout, if_m.sout_valid, if_m.frame_start, if_m.word_done};
    n_checks++;
    if (got !== 4'b1110) begin
      n_fail++;
      $display("FAIL abort_bit0: got %b expected 1110", got);
    end
    @(negedge clk);
    got = {if_m.sout, if_m.sout_valid, if_m.frame_start, if_m.word_done};
    n_checks++;
    if (got !== 4'b0100) begin
      n_fail++;
      $display("FAIL abort_bit1: got %b expected 0100", got);
    end
    reset = 1'b1;
    @(negedge clk);
    got = {if_m.sout, if_m.sout_valid, if_m.frame_start, if_m.word_done};
    n_checks++;
    if (got !== 4'b0000 || if_m.load_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_reset: got %b ready %b expected 0000 ready 0", got, if_m.load_ready);
    end
    reset = 1'b0;
    @(negedge clk);
    got = {if_m.sout, if_m.sout_valid, if_m.frame_start, if_m.word_done};
    n_checks++;
    if (got !== 4'b0000 || if_m.load_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_no_done: got %b ready %b expected 0000 ready 1", got, if_m.load_ready);
    end
    seq = 4'b0110;
    if_m.din = 4'b0110; if_m.load_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) if_m.load_valid = 1'b0;
      got = {if_m.sout, if_m.sout_valid, if_m.frame_start, if_m.word_done};
      n_checks++;
      if (got !== {seq[3-k], 1'b1, (k == 0), 1'b0}) begin
        n_fail++;
        $display("FAIL fresh_bit[%0d]: got %b expected %b", k, got, {seq[3-k], 1'b1, (k == 0), 1'b0});
      end
    end
    @(negedge clk);
    got = {if_m.sout, if_m.sout_valid, if_m.frame_start, if_m.word_done};
    n_checks++;
    if (got !== 4'b0001) begin
      n_fail++;
      $display("FAIL fresh_done: got %b expected 0001", got);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_msb_single();
    test_lsb_first();
    test_back_to_back();
    test_gated_rate();
    test_reset_mid_frame();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
